dm_mem_model: RTL
=================

Name: dm_mem_model

Overview:
- Cycle-accurate backing-memory model on the memory side of the direct-mapped cache. It consumes the cache's o_mem_* request bus and drives the i_mem_* response signals.
- Serves one outstanding block-sized read or write at a time, with parameterised latency.
- Exports completion counters for bench scoreboarding.

Parameters:
- ADDRESS_WIDTH, 64: request address width.
- WRITE_DATA, 64: block size in bytes; the data bus is WRITE_DATA*8 bits.
- BLOCK_SIZE_BITS, 6: byte-offset bits, ignored for indexing.
- MEM_DEPTH_BITS, 8: index bits; the array holds 2**MEM_DEPTH_BITS blocks.
- READ_LATENCY, 4: cycles from request accept to o_mem_read_valid. Legal range 1..255.
- WRITE_LATENCY, 2: cycles from request accept to the write-ack pulse. Legal range 1..255.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- i_mem_valid, input, 1: request valid. Held by the requester until completion.
- i_mem_rd_wr, input, 1: 0 = read, 1 = write.
- i_mem_address, input, ADDRESS_WIDTH: block address.
- o_mem_ready, output, 1: one-cycle write-acknowledge pulse.
- i_mem_write_data, input, WRITE_DATA*8: write block.
- o_mem_read_data, output, WRITE_DATA*8: read block.
- o_mem_read_valid, output, 1: read data valid.
- i_mem_read_ready, input, 1: requester accepts read data.
- o_busy, output, 1: a request is in flight (any state other than IDLE).
- o_rd_count, output, 32: completed reads.
- o_wr_count, output, 32: completed writes.

Behaviour:
- Index is i_mem_address[BLOCK_SIZE_BITS+MEM_DEPTH_BITS-1:BLOCK_SIZE_BITS]. Higher address bits are ignored, so addresses alias.
- Reset (rst high at an edge) wins over everything:
  - state goes to IDLE and the latency counter to 0;
  - all outputs go to 0, including the counters;
  - every array word is cleared to 0;
  - an in-flight write is not committed and an in-flight read is dropped.
- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, REARM.
- IDLE:
  - On an edge with i_mem_valid=1, capture rd_wr, index and write data into internal registers. Later input changes are ignored.
  - Load the counter with READ_LATENCY-1 for a read or WRITE_LATENCY-1 for a write.
  - Go to RD_WAIT (read) or WR_WAIT (write).
- RD_WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0, load o_mem_read_data from the array, set o_mem_read_valid=1 and go to RD_RESP.
  - Net effect: accept at edge T, read_valid visible from edge T+READ_LATENCY.
- RD_RESP:
  - Hold o_mem_read_valid and data stable until an edge with i_mem_read_ready=1.
  - At that edge: clear read_valid, increment o_rd_count, go to REARM.
- WR_WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0: write the captured data to the array, set o_mem_ready=1 for exactly one cycle, increment o_wr_count, go to REARM.
  - Net effect: ack visible from edge T+WRITE_LATENCY.
- REARM:
  - Stay until an edge with i_mem_valid=0, then go to IDLE.
  - This prevents a requester that holds valid after completion from re-issuing the same request.
  - The earliest next accept is one cycle after valid is observed low.
- o_mem_ready is 0 in every state except the single ack cycle. It is never asserted for reads.
- o_mem_read_data keeps its last value when not valid.
- Counters wrap from 2**32-1 to 0.
- With a latency of 1, the response appears on the edge after accept, i.e. there are zero wait cycles.
- i_mem_valid dropping mid-request does not abort it. Only rst aborts.
- A read of a never-written index returns 0.
- A read that follows a write to the same index returns the written data. No bypass is needed because requests are single-outstanding.

Test Plan:
- Write then read back: reset; write addr 0x40 with data {8{64'hA5A5_0000_0000_0001}}, ack at accept+2; drop valid; read 0x40 → read_valid at accept+4, same data, o_wr_count=1, o_rd_count=1.
- Read-ready backpressure: hold i_mem_read_ready=0 for 5 cycles after read_valid → data and valid stay stable; raise ready → valid falls the next cycle, o_rd_count increments exactly once.
- Held valid: keep i_mem_valid=1 for 10 cycles after the write ack → no second ack, o_wr_count stays 1, o_busy=1 until valid drops, then o_busy=0 one cycle later.
- Aliasing and boundary: write index 255 (addr 0x3FC0) with pattern P, then read addr 0x7FC0 → returns P; read unwritten index 3 (addr 0xC0) → returns 0.
- Reset mid-write: accept a write to 0x80 with WRITE_LATENCY=2, assert rst on the next edge → no ack, all outputs 0; a subsequent read of 0x80 returns 0.
- Latency sweep: with READ_LATENCY=1 and WRITE_LATENCY=1, read_valid/ack appear exactly one edge after accept; with READ_LATENCY=255, read_valid appears exactly at accept+255.

Source files
------------

// File: rtl/dm_mem_model.sv
// Cycle-accurate backing-memory model for the memory side of the direct-mapped cache.
// Serves one block-sized read or write at a time with fixed, parameterised latency.
module dm_mem_model #(
    parameter int unsigned ADDRESS_WIDTH   = 64,
    parameter int unsigned WRITE_DATA      = 64,
    parameter int unsigned BLOCK_SIZE_BITS = 6,
    parameter int unsigned MEM_DEPTH_BITS  = 8,
    parameter int unsigned READ_LATENCY    = 4,
    parameter int unsigned WRITE_LATENCY   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_mem_valid,
    input  logic                       i_mem_rd_wr,
    input  logic [ADDRESS_WIDTH-1:0]   i_mem_address,
    output logic                       o_mem_ready,
    input  logic [WRITE_DATA*8-1:0]    i_mem_write_data,
    output logic [WRITE_DATA*8-1:0]    o_mem_read_data,
    output logic                       o_mem_read_valid,
    input  logic                       i_mem_read_ready,
    output logic                       o_busy,
    output logic [31:0]                o_rd_count,
    output logic [31:0]                o_wr_count
);

    localparam int unsigned DATA_W = WRITE_DATA * 8;
    localparam int unsigned DEPTH  = 1 << MEM_DEPTH_BITS;
    localparam int unsigned IDX_LO = BLOCK_SIZE_BITS;
    localparam int unsigned IDX_HI = BLOCK_SIZE_BITS + MEM_DEPTH_BITS - 1;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        REARM   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [MEM_DEPTH_BITS-1:0] idx_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [DATA_W-1:0]         read_data_q;
    logic                      read_valid_q, valid_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic [31:0]               rd_count_q, wr_count_q;
    logic                      capture, mem_we, rd_load, rd_inc, wr_inc;
    logic [DATA_W-1:0]         mem [DEPTH];

    // Offset and aliased upper address bits play no part in indexing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_mem_address[ADDRESS_WIDTH-1:IDX_HI+1],
                                i_mem_address[IDX_LO-1:0]};

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        mem_we  = 1'b0;
        rd_load = 1'b0;
        rd_inc  = 1'b0;
        wr_inc  = 1'b0;
        ready_d = 1'b0;
        valid_d = read_valid_q;
        case (state_q)
            IDLE: begin
                if (i_mem_valid) begin
                    capture = 1'b1;
                    if (i_mem_rd_wr) begin
                        cnt_d   = CNT_W'(WRITE_LATENCY - 1);
                        state_d = WR_WAIT;
                    end else begin
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rd_load = 1'b1;
                    valid_d = 1'b1;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: begin
                if (i_mem_read_ready) begin
                    valid_d = 1'b0;
                    rd_inc  = 1'b1;
                    state_d = REARM;
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we  = 1'b1;
                    ready_d = 1'b1;
                    wr_inc  = 1'b1;
                    state_d = REARM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REARM: begin
                // Wait for the requester to drop valid so a held request is not replayed.
                if (!i_mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Request capture, array access, response outputs and completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            wdata_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            read_valid_q <= valid_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            if (capture) begin
                idx_q   <= i_mem_address[IDX_HI:IDX_LO];
                wdata_q <= i_mem_write_data;
            end
            if (mem_we) begin
                mem[idx_q] <= wdata_q;
            end
            if (rd_load) begin
                read_data_q <= mem[idx_q];
            end
            if (rd_inc) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (wr_inc) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

    assign o_mem_ready      = ready_q;
    assign o_mem_read_data  = read_data_q;
    assign o_mem_read_valid = read_valid_q;
    assign o_busy           = busy_q;
    assign o_rd_count       = rd_count_q;
    assign o_wr_count       = wr_count_q;

endmodule
